// File: rtl/mouv_sample_analyzer_if.sv
// Sample stream bundle for the movement-analysis front end: valid/ready plus
// three signed accelerometer axes.
interface mouv_sample_analyzer_if #(
    parameter int SAMPLE_W = 16
);
    logic                       s_valid;
    logic                       s_ready;
    logic signed [SAMPLE_W-1:0] s_x;
    logic signed [SAMPLE_W-1:0] s_y;
    logic signed [SAMPLE_W-1:0] s_z;

    modport master (output s_valid, s_x, s_y, s_z, input s_ready);
    modport slave  (input s_valid, s_x, s_y, s_z, output s_ready);
endinterface

// File: rtl/mouv_sample_analyzer.sv
// L1 magnitude, debounced movement detection and window averaging of 3-axis samples.
// Optional peak-magnitude hold is built when MOUV_PEAK_HOLD_EN is defined.
//
// state   | meaning
// IDLE    | no movement; waiting for a magnitude above threshold
// RISING  | above threshold for cnt consecutive samples, not yet debounced
// ACTIVE  | movement event registered; magnitudes above threshold
// FALLING | still active; below-or-equal for cnt consecutive samples
module mouv_sample_analyzer #(
    parameter int SAMPLE_W    = 16,
    parameter int WINDOW_LOG2 = 5,
    parameter int DEBOUNCE    = 4
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    mouv_sample_analyzer_if.slave s,
    input  logic                  cfg_enable,
    input  logic [SAMPLE_W+1:0]   cfg_threshold,
    input  logic                  clear,
    output logic [SAMPLE_W+1:0]   mag_out,
    output logic                  mag_valid,
    output logic                  active,
    output logic [31:0]           event_count,
    output logic                  irq,
    output logic [SAMPLE_W+1:0]   window_avg,
    output logic                  window_valid
`ifdef MOUV_PEAK_HOLD_EN
    ,
    output logic [SAMPLE_W+1:0]   peak_mag
`endif
);
    localparam int ABS_W = SAMPLE_W + 1;
    localparam int MAG_W = SAMPLE_W + 2;
    localparam int ACC_W = MAG_W + WINDOW_LOG2;
    localparam logic [3:0] DEB = 4'(DEBOUNCE);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RISING  = 2'd1,
        ST_ACTIVE  = 2'd2,
        ST_FALLING = 2'd3
    } state_t;

    // Sign-extend by one bit first so the most negative sample negates cleanly.
    function automatic logic [ABS_W-1:0] abs_ext(input logic [SAMPLE_W-1:0] v);
        logic [ABS_W-1:0] e;
        e = {v[SAMPLE_W-1], v};
        return e[ABS_W-1] ? ((~e) + ABS_W'(1)) : e;
    endfunction

    logic             xfer;
    logic             v1;
    logic [ABS_W-1:0] abs_x, abs_y, abs_z;
    logic [MAG_W-1:0] mag_sum;
    logic             above;

    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             event_hit;

    logic [ACC_W-1:0]       acc;
    logic [ACC_W-1:0]       acc_sum;
    logic [WINDOW_LOG2-1:0] idx;

    assign s.s_ready = cfg_enable & ~clear & ~ARESET;
    assign xfer      = s.s_valid & s.s_ready;

    // stage 1: absolute values
    always_ff @(posedge ACLK) begin
        if (ARESET || clear) begin
            v1 <= 1'b0;
        end else begin
            v1 <= xfer;
        end
        if (ARESET) begin
            abs_x <= '0;
            abs_y <= '0;
            abs_z <= '0;
        end else if (xfer) begin
            abs_x <= abs_ext(s.s_x);
            abs_y <= abs_ext(s.s_y);
            abs_z <= abs_ext(s.s_z);
        end
    end

    assign mag_sum = MAG_W'(abs_x) + MAG_W'(abs_y) + MAG_W'(abs_z);

    // stage 2: magnitude register; clear drops the in-flight sample but keeps mag_out
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            mag_out   <= '0;
            mag_valid <= 1'b0;
        end else begin
            mag_valid <= v1 & ~clear;
            if (v1 && !clear) begin
                mag_out <= mag_sum;
            end
        end
    end

    assign above = mag_out > cfg_threshold;

    // stage 3: debounce FSM
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        event_hit = 1'b0;
        if (clear) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else if (mag_valid) begin
            case (state_q)
                ST_IDLE: begin
                    if (above) begin
                        if (DEB == 4'd1) begin
                            state_d   = ST_ACTIVE;
                            cnt_d     = '0;
                            event_hit = 1'b1;
                        end else begin
                            state_d = ST_RISING;
                            cnt_d   = 4'd1;
                        end
                    end
                end
                ST_RISING: begin
                    if (above) begin
                        if (cnt_q + 4'd1 == DEB) begin
                            state_d   = ST_ACTIVE;
                            cnt_d     = '0;
                            event_hit = 1'b1;
                        end else begin
                            cnt_d = cnt_q + 4'd1;
                        end
                    end else begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end
                end
                ST_ACTIVE: begin
                    if (!above) begin
                        if (DEB == 4'd1) begin
                            state_d = ST_IDLE;
                            cnt_d   = '0;
                        end else begin
                            state_d = ST_FALLING;
                            cnt_d   = 4'd1;
                        end
                    end
                end
                ST_FALLING: begin
                    if (!above) begin
                        if (cnt_q + 4'd1 == DEB) begin
                            state_d = ST_IDLE;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + 4'd1;
                        end
                    end else begin
                        state_d = ST_ACTIVE;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            event_count <= '0;
            irq         <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            irq     <= event_hit;
            if (clear) begin
                event_count <= '0;
            end else if (event_hit && (event_count != '1)) begin
                event_count <= event_count + 32'd1;
            end
        end
    end

    assign active = (state_q == ST_ACTIVE) || (state_q == ST_FALLING);

    // stage 3: window accumulator
    assign acc_sum = acc + ACC_W'(mag_out);

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            acc          <= '0;
            idx          <= '0;
            window_avg   <= '0;
            window_valid <= 1'b0;
        end else begin
            window_valid <= 1'b0;
            if (clear) begin
                acc <= '0;
                idx <= '0;
            end else if (mag_valid) begin
                if (idx == '1) begin
                    window_avg   <= acc_sum[ACC_W-1:WINDOW_LOG2];
                    acc          <= '0;
                    idx          <= '0;
                    window_valid <= 1'b1;
                end else begin
                    acc <= acc_sum;
                    idx <= idx + 1'b1;
                end
            end
        end
    end

`ifdef MOUV_PEAK_HOLD_EN
    // peak follows stage 2 so it updates together with mag_out
    always_ff @(posedge ACLK) begin
        if (ARESET || clear) begin
            peak_mag <= '0;
        end else if (v1 && (mag_sum > peak_mag)) begin
            peak_mag <= mag_sum;
        end
    end
`else
    // no peak tracking in this build
`endif

endmodule

// File: tb/tb_mouv_sample_analyzer.sv
// Bench for mouv_sample_analyzer: directed test-plan steps plus randomized traffic
// against a cycle-level reference model of the analyzer's behaviour.
module tb_mouv_sample_analyzer;
    localparam int SW  = 16;
    localparam int WL  = 5;
    localparam int DEB = 4;
    localparam int MW  = SW + 2;

    logic          ACLK = 1'b0;
    logic          ARESET;
    logic          cfg_enable;
    logic [MW-1:0] cfg_threshold;
    logic          clear;
    logic [MW-1:0] mag_out;
    logic          mag_valid;
    logic          active;
    logic [31:0]   event_count;
    logic          irq;
    logic [MW-1:0] window_avg;
    logic          window_valid;
`ifdef MOUV_PEAK_HOLD_EN
    logic [MW-1:0] peak_mag;
`endif

    mouv_sample_analyzer_if #(.SAMPLE_W(SW)) bus ();

    mouv_sample_analyzer #(
        .SAMPLE_W   (SW),
        .WINDOW_LOG2(WL),
        .DEBOUNCE   (DEB)
    ) dut (
        .ACLK         (ACLK),
        .ARESET       (ARESET),
        .s            (bus),
        .cfg_enable   (cfg_enable),
        .cfg_threshold(cfg_threshold),
        .clear        (clear),
        .mag_out      (mag_out),
        .mag_valid    (mag_valid),
        .active       (active),
        .event_count  (event_count),
        .irq          (irq),
        .window_avg   (window_avg),
        .window_valid (window_valid)
`ifdef MOUV_PEAK_HOLD_EN
        ,
        .peak_mag     (peak_mag)
`endif
    );

    always #5 ACLK = ~ACLK;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state
    int     m_mag_out, m_win_avg, m_peak, m_streak, m_wn;
    bit     m_mag_valid, m_irq, m_wv, m_active;
    longint m_evt, m_ws;
    bit     s1_v, s2_v;
    int     s1_m, s2_m;
    int     wv_seen;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    task automatic model_reset_all();
        m_mag_out = 0; m_win_avg = 0; m_peak = 0; m_streak = 0; m_wn = 0;
        m_mag_valid = 0; m_irq = 0; m_wv = 0; m_active = 0;
        m_evt = 0; m_ws = 0; s1_v = 0; s2_v = 0; s1_m = 0; s2_m = 0;
    endtask

    // one compared magnitude: debounce as "mode + streak of contrary samples", window as running sum
    task automatic model_compare(input int m, input int thr);
        bit above;
        above = (m > thr);
        if (!m_active) begin
            if (above) begin
                m_streak++;
                if (m_streak >= DEB) begin
                    m_active = 1; m_streak = 0; m_irq = 1;
                    if (m_evt < 64'hFFFF_FFFF) m_evt++;
                end
            end else m_streak = 0;
        end else begin
            if (!above) begin
                m_streak++;
                if (m_streak >= DEB) begin m_active = 0; m_streak = 0; end
            end else m_streak = 0;
        end
        m_ws += m;
        m_wn++;
        if (m_wn == (1 << WL)) begin
            m_win_avg = int'(m_ws >> WL);
            m_wv = 1; m_ws = 0; m_wn = 0;
        end
    endtask

    task automatic check_all();
        chk("mag_valid", mag_valid, m_mag_valid);
        chk("mag_out", mag_out, m_mag_out);
        chk("active", active, m_active);
        chk("event_count", event_count, m_evt[31:0]);
        chk("irq", irq, m_irq);
        chk("window_valid", window_valid, m_wv);
        chk("window_avg", window_avg, m_win_avg);
`ifdef MOUV_PEAK_HOLD_EN
        chk("peak_mag", peak_mag, m_peak);
`endif
    endtask

    // drive one cycle (called at a negedge), update the model at the posedge, check at next negedge
    task automatic cycle(input bit v, input int x, input int y, input int z, input bit clr);
        bit xfer;
        int mm, thr;
        bus.s_valid = v;
        bus.s_x = 16'(x);
        bus.s_y = 16'(y);
        bus.s_z = 16'(z);
        clear = clr;
        #1;
        chk("s_ready", bus.s_ready, cfg_enable & ~clr);
        xfer = v && cfg_enable && !clr;
        mm   = iabs(x) + iabs(y) + iabs(z);
        thr  = int'(cfg_threshold);
        @(posedge ACLK);
        if (clr) begin
            m_mag_valid = 0; m_irq = 0; m_wv = 0; s1_v = 0; s2_v = 0;
            m_active = 0; m_streak = 0; m_evt = 0; m_ws = 0; m_wn = 0; m_peak = 0;
        end else begin
            m_irq = 0; m_wv = 0;
            if (s2_v) model_compare(s2_m, thr);
            m_mag_valid = s1_v;
            if (s1_v) begin
                m_mag_out = s1_m;
                if (s1_m > m_peak) m_peak = s1_m;
            end
            s2_v = s1_v; s2_m = s1_m;
            s1_v = xfer; s1_m = mm;
        end
        @(negedge ACLK);
        check_all();
        if (window_valid === 1'b1) wv_seen++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        ARESET = 1; cfg_enable = 0; clear = 0; bus.s_valid = 0;
        repeat (2) @(posedge ACLK);
        @(negedge ACLK);
        model_reset_all();
        chk("s_ready_rst", bus.s_ready, 1'b0);
        check_all();
        ARESET = 0;
    endtask

    initial begin
        logic signed [15:0] r16;
        int rx, ry, rz;
        bit rv, rc;

        bus.s_x = '0; bus.s_y = '0; bus.s_z = '0;
        cfg_threshold = '0;
        do_reset();

        // most negative axis magnitude
        cfg_enable = 1;
        cycle(1, -32768, 32767, 0, 0);
        cycle(0, 0, 0, 0, 0);
        chk("tp_mag_65535", mag_out, 18'd65535);
        chk("tp_mag_valid", mag_valid, 1'b1);
        idle(3);

        // debounce into ACTIVE
        cfg_threshold = 18'd1000;
        cycle(0, 0, 0, 0, 1);
        for (int i = 0; i < 4; i++) cycle(1, -700, 500, -300, 0);
        idle(2);
        chk("tp_irq", irq, 1'b1);
        chk("tp_active", active, 1'b1);
        chk("tp_evt1", event_count, 32'd1);
        idle(1);
        chk("tp_irq_pulse", irq, 1'b0);

        // dip shorter than debounce keeps ACTIVE
        for (int i = 0; i < 3; i++) cycle(1, 200, -200, 100, 0);
        cycle(1, -700, 500, -300, 0);
        idle(3);
        chk("tp_still_active", active, 1'b1);
        chk("tp_still_evt1", event_count, 32'd1);
        for (int i = 0; i < 4; i++) cycle(1, 200, -200, 100, 0);
        idle(3);
        chk("tp_fell", active, 1'b0);

        // 999 breaks the rising run
        cycle(0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) cycle(1, 1500, 0, 0, 0);
        cycle(1, 999, 0, 0, 0);
        idle(3);
        chk("tp_no_event", event_count, 32'd0);
        chk("tp_idle", active, 1'b0);

        // window averaging
        cycle(0, 0, 0, 0, 1);
        wv_seen = 0;
        for (int i = 0; i < 32; i++) cycle(1, i, 0, 0, 0);
        cycle(1, 100, 0, 0, 0);
        idle(3);
        chk("tp_win_pulses", wv_seen, 1);
        chk("tp_win_avg15", window_avg, 18'd15);
        for (int i = 0; i < 31; i++) cycle(1, 0, -64, 0, 0);
        idle(3);
        chk("tp_win2_avg65", window_avg, 18'd65);

        // clear with a pending transfer
        cycle(0, 0, 0, 0, 1);
        for (int e = 0; e < 7; e++) begin
            for (int i = 0; i < 4; i++) cycle(1, -700, 500, -300, 0);
            for (int i = 0; i < 4; i++) cycle(1, 200, -200, 100, 0);
        end
        idle(3);
        chk("tp_evt7", event_count, 32'd7);
        cycle(1, 1500, 0, 0, 1);
        chk("tp_clr_evt0", event_count, 32'd0);
        idle(3);
        chk("tp_clr_mag_kept", mag_out, 18'd500);
        chk("tp_clr_no_xfer", mag_valid, 1'b0);
        for (int i = 0; i < 32; i++) cycle(1, 32, 0, 0, 0);
        idle(3);
        chk("tp_clr_acc0", window_avg, 18'd32);

`ifdef MOUV_PEAK_HOLD_EN
        cycle(0, 0, 0, 0, 1);
        cycle(1, 300, 0, 0, 0);
        cycle(1, 0, -900, 0, 0);
        cycle(1, 0, 0, 200, 0);
        idle(3);
        chk("tp_peak900", peak_mag, 18'd900);
        cycle(0, 0, 0, 0, 1);
        chk("tp_peak_clr", peak_mag, 18'd0);
`endif

        // randomized traffic, with a reset in the middle
        for (int n = 0; n < 600; n++) begin
            if (n == 300) begin
                do_reset();
                cfg_enable = 1;
            end
            if ($urandom_range(0, 15) == 0) cfg_enable = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 31) == 0) cfg_threshold = 18'($urandom_range(10000, 90000));
            r16 = 16'($urandom); rx = int'(r16);
            r16 = 16'($urandom); ry = int'(r16);
            r16 = 16'($urandom); rz = int'(r16);
            if ($urandom_range(0, 9) == 0) begin rx = -32768; ry = -32768; rz = -32768; end
            rv = ($urandom_range(0, 3) != 0);
            rc = ($urandom_range(0, 60) == 0);
            cycle(rv, rx, ry, rz, rc);
        end
        idle(4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/mouv_sample_analyzer.md
# mouv_sample_analyzer

- Upstream feature-extraction stage of the movement-analysis IP.
- Accepts 3-axis signed accelerometer samples on a valid/ready stream.
- Computes the L1 magnitude of each sample, detects debounced movement events against a programmable threshold, and produces 2^WINDOW_LOG2-sample window averages.
- All results are held in registers that the AXI4-Lite register bank reads directly. Threshold, enable and clear are written by that bank.

## Interface
Parameters:
- SAMPLE_W, 16: signed axis sample width.
- WINDOW_LOG2, 5: window length is 2^WINDOW_LOG2 magnitudes (32).
- DEBOUNCE, 4: consecutive samples needed to enter or leave ACTIVE; range 1..15.

Ports:
- ACLK  in  1  system clock; all logic on rising edge.
- ARESET  in  1  synchronous, active-high reset.
- s_valid  in  1  sample valid.
- s_ready  out  1  sample ready; equals cfg_enable & ~clear.
- s_x, s_y, s_z  in  SAMPLE_W each  signed two's-complement axis samples.
- cfg_enable  in  1  accept samples when high.
- cfg_threshold  in  SAMPLE_W+2  unsigned magnitude threshold.
- clear  in  1  single-cycle pulse that clears statistics.
- mag_out  out  SAMPLE_W+2  last computed magnitude.
- mag_valid  out  1  1-cycle pulse when mag_out updates.
- active  out  1  high while the FSM is in ACTIVE or FALLING.
- event_count  out  32  count of debounced movement events; saturating.
- irq  out  1  1-cycle pulse on each new event.
- window_avg  out  SAMPLE_W+2  average of the last completed window.
- window_valid  out  1  1-cycle pulse when window_avg updates.
- peak_mag  out  SAMPLE_W+2  maximum magnitude since clear. Present only with MOUV_PEAK_HOLD_EN.

## Operation
- A transfer occurs when s_valid & s_ready. There is no downstream backpressure; the pipeline never stalls.
- Stage 1: register |s_x|, |s_y|, |s_z|, each SAMPLE_W+1 bits unsigned, so -32768 gives 32768 with no overflow.
- Stage 2: magnitude = sum of the three, SAMPLE_W+2 bits, maximum 98304. Registered into mag_out; mag_valid pulses.
- Stage 3 compares mag > cfg_threshold (strictly greater) and runs the FSM.
- FSM states: IDLE, RISING, ACTIVE, FALLING, with a 4-bit debounce counter cnt.
  - IDLE: above threshold -> RISING, cnt=1. If DEBOUNCE==1, go straight to ACTIVE and register an event.
  - RISING: above threshold -> cnt+1; when cnt reaches DEBOUNCE -> ACTIVE and register an event. Below or equal -> IDLE.
  - ACTIVE: below or equal -> FALLING, cnt=1 (DEBOUNCE==1 -> IDLE). Above -> stay.
  - FALLING: below or equal -> cnt+1; when cnt reaches DEBOUNCE -> IDLE. Above -> ACTIVE; no new event.
- Registering an event: event_count+1, saturating at 0xFFFFFFFF; irq pulses even when the count is saturated.
- Window accumulator is SAMPLE_W+2+WINDOW_LOG2 bits with a WINDOW_LOG2-bit sample index.
  - On the 2^WINDOW_LOG2-th magnitude: window_avg <= (acc+mag) >> WINDOW_LOG2, truncated; acc <= 0; index wraps to 0; window_valid pulses.
- clear: FSM -> IDLE; cnt, acc, index, event_count and peak_mag -> 0; in-flight pipeline stages are discarded.
  - mag_out and window_avg keep their values.
  - clear wins over a same-cycle transfer; s_ready is low that cycle, so no transfer can occur.
- cfg_enable falling: s_ready drops immediately; samples already in flight complete normally.
- cfg_threshold is sampled in stage 3 on every magnitude; changes take effect on the next compared magnitude.

## Timing
- Transfer in cycle N -> mag_out/mag_valid at N+2.
- FSM state, event_count, irq, window_avg and window_valid update at N+3.
- Throughput: one sample per cycle.
- Reset values: every output is 0, including s_ready, which follows cfg_enable from the first cycle after reset. FSM state is IDLE.
- ARESET mid-operation: all pipeline contents lost; next accepted sample starts window index 0.

## Configuration
- MOUV_PEAK_HOLD_EN defined:
  - peak_mag port and register exist; updated at N+2 with max(peak_mag, mag).
  - Cleared by ARESET and clear.
- MOUV_PEAK_HOLD_EN undefined: no peak_mag port and no comparator.

## Test plan
- Reset, cfg_enable=1, sample (-32768, 32767, 0): mag_out=65535 two cycles after the transfer, with mag_valid.
- Threshold 1000, DEBOUNCE=4:
  - Magnitudes 1500 x4 -> active=1, event_count=1, irq one pulse at the 4th sample +3 cycles.
  - Then 500 x3, 1500 -> still active, event_count=1.
  - Then 500 x4 -> active=0.
- Threshold 1000: 1500 x3 then 999 -> no event; event_count=0, FSM back in IDLE.
- 32 back-to-back samples with magnitudes 0..31 -> a single window_valid, window_avg=15. The 33rd sample starts a new window.
- clear asserted in the same cycle as s_valid with an event_count of 7 -> s_ready=0, no transfer, event_count=0, acc=0. mag_out unchanged.
- With MOUV_PEAK_HOLD_EN: magnitudes 300, 900, 200 -> peak_mag=900. After clear -> peak_mag=0.
